// File: rtl/spkr_inv_pkg.sv
// Shared types and helpers for the serial speaker inverter.
// Optional delay line is enabled with the SPKR_INV_DELAY_EN macro.
package spkr_inv_pkg;

  // Per-channel processing mode
  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_MIRROR = 2'b01,
    MODE_MUTE   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Frame sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SCAN = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Midscale code for a w-bit unsigned sample
  function automatic logic [31:0] midscale(input int unsigned w);
    return 32'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/spkr_inverter_seq_if.sv
// Frame bus between sample source, inverter and DAC side.
// dly_sel exists only when SPKR_INV_DELAY_EN is defined.
interface spkr_inverter_seq_if #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned W         = 12,
  parameter int unsigned DLY_DEPTH = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [N_CH*W-1:0]   in_data;
  logic [2*N_CH-1:0]   mode;
  logic                out_valid;
  logic [N_CH*W-1:0]   out_data;
  logic                busy;

`ifdef SPKR_INV_DELAY_EN
  localparam int unsigned DW = (DLY_DEPTH > 1) ? $clog2(DLY_DEPTH) : 1;
  logic [N_CH*DW-1:0]  dly_sel;

  modport master (output in_valid, in_data, mode, dly_sel,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, mode, dly_sel,
                  output in_ready, out_valid, out_data, busy);
`else
  modport master (output in_valid, in_data, mode,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, mode,
                  output in_ready, out_valid, out_data, busy);
`endif

endinterface

// File: rtl/spkr_inv_mirror.sv
// Combinational single-sample mode apply: pass, mirror, mute or hold.
module spkr_inv_mirror
  import spkr_inv_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] i_x,
  input  mode_e        i_mode,
  input  logic [W-1:0] i_prev,
  output logic [W-1:0] o_y_c
);

  localparam logic [W-1:0] MID = W'(midscale(W));

  // Mirror about full scale is a bitwise invert for unsigned samples
  always_comb begin
    o_y_c = i_x;
    case (i_mode)
      MODE_PASS:   o_y_c = i_x;
      MODE_MIRROR: o_y_c = ~i_x;
      MODE_MUTE:   o_y_c = MID;
      MODE_HOLD:   o_y_c = i_prev;
      default:     o_y_c = i_x;
    endcase
  end

endmodule

// File: rtl/spkr_inverter_seq.sv
// N-channel speaker inverter, channels processed serially through one
// mode-apply datapath. Define SPKR_INV_DELAY_EN to add a per-channel
// delay line selected by dly_sel.
module spkr_inverter_seq
  import spkr_inv_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned W         = 12,
  parameter int unsigned DLY_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  spkr_inverter_seq_if.slave  sif
);

  localparam int unsigned  CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [W-1:0] MID = W'(midscale(W));

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_accept;
  logic [CW-1:0]   r_ch_idx;
  logic [W-1:0]    r_stage [N_CH];
  logic [W-1:0]    r_out   [N_CH];
  mode_e           r_mode  [N_CH];
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [W-1:0]    w_x;
  logic [W-1:0]    w_y;

`ifdef SPKR_INV_DELAY_EN
  localparam int unsigned DW = (DLY_DEPTH > 1) ? $clog2(DLY_DEPTH) : 1;
  logic [W-1:0]    r_dly  [N_CH][DLY_DEPTH];
  logic [DW-1:0]   r_wptr;
  logic [DW-1:0]   r_dsel [N_CH];
  logic [DW-1:0]   w_rd_ptr;

  // Current frame sits one behind the write pointer; step back dsel more
  always_comb begin
    w_rd_ptr = r_wptr - DW'(1) - r_dsel[r_ch_idx];
    w_x      = r_dly[r_ch_idx][w_rd_ptr];
  end

  // Delay line: one write per accepted frame, reset to midscale
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      for (int k = 0; k < N_CH; k++) begin
        r_dsel[k] <= '0;
        for (int d = 0; d < DLY_DEPTH; d++) r_dly[k][d] <= MID;
      end
    end else if (w_accept) begin
      r_wptr <= r_wptr + DW'(1);
      for (int k = 0; k < N_CH; k++) begin
        r_dly[k][r_wptr] <= sif.in_data[k*W +: W];
        r_dsel[k]        <= sif.dly_sel[k*DW +: DW];
      end
    end
  end
`else
  logic [W-1:0]    r_shadow [N_CH];

  always_comb w_x = r_shadow[r_ch_idx];

  // Shadow copy of the accepted frame
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) r_shadow[k] <= MID;
    end else if (w_accept) begin
      for (int k = 0; k < N_CH; k++) r_shadow[k] <= sif.in_data[k*W +: W];
    end
  end
`endif

  spkr_inv_mirror #(.W(W)) u_mirror (
    .i_x    (w_x),
    .i_mode (r_mode[r_ch_idx]),
    .i_prev (r_out[r_ch_idx]),
    .o_y_c  (w_y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and accept decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sif.in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN:  if (r_ch_idx == CW'(N_CH - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Channel scan, staging, output registers and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_idx    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_stage[k] <= MID;
        r_out[k]   <= MID;
        r_mode[k]  <= MODE_PASS;
      end
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_out_valid <= (r_state == S_DONE);
      if (w_accept) begin
        r_ch_idx <= '0;
        for (int k = 0; k < N_CH; k++) r_mode[k] <= mode_e'(sif.mode[2*k +: 2]);
      end else if (r_state == S_SCAN) begin
        r_stage[r_ch_idx] <= w_y;
        r_ch_idx          <= r_ch_idx + CW'(1);
      end
      if (r_state == S_DONE) begin
        for (int k = 0; k < N_CH; k++) r_out[k] <= r_stage[k];
      end
    end
  end

  assign sif.in_ready  = r_in_ready;
  assign sif.out_valid = r_out_valid;
  assign sif.busy      = r_busy;

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign sif.out_data[g*W +: W] = r_out[g];
  end

endmodule

// File: tb/tb_spkr_inverter_seq.sv
// Directed bench for spkr_inverter_seq at N_CH=4, W=12.
// Delay-line vectors run only when SPKR_INV_DELAY_EN is defined.
module tb_spkr_inverter_seq;

  localparam int unsigned N_CH = 4;
  localparam int unsigned W    = 12;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   strobes;

  spkr_inverter_seq_if #(.N_CH(N_CH), .W(W), .DLY_DEPTH(8)) bus ();

  spkr_inverter_seq #(.N_CH(N_CH), .W(W), .DLY_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .sif (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count out_valid strobes (pre-update sample at each rising edge)
  always @(posedge clk) begin
    if (rst) strobes <= 0;
    else if (bus.out_valid) strobes <= strobes + 1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [47:0] pk(input logic [11:0] c0, input logic [11:0] c1,
                                     input logic [11:0] c2, input logic [11:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Streaming pattern: channel k of cycle c carries c*8+k
  function automatic logic [47:0] pkc(input int c);
    return pk(12'(c*8), 12'(c*8 + 1), 12'(c*8 + 2), 12'(c*8 + 3));
  endfunction

  task automatic set_dsel(input logic [11:0] v);
`ifdef SPKR_INV_DELAY_EN
    bus.dly_sel = v;
`else
    if (v != 12'h000) $display("note: dly_sel ignored in this build");
`endif
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  // Send one frame, then scramble the inputs so late changes must be ignored
  task automatic run_frame(input string tag, input logic [47:0] d, input logic [7:0] m,
                           input logic [47:0] exp);
    int n;
    int s0;
    wait_ready(tag);
    s0           = strobes;
    bus.in_data  = d;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 48'h0;
    bus.mode     = 8'h00;
    set_dsel(12'h000);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(n), 64'd5);
    chk({tag, "_data"}, 64'(bus.out_data), 64'(exp));
    @(negedge clk);
    chk({tag, "_strobe1"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_nstrobe"}, 64'(strobes - s0), 64'd1);
  endtask

  initial begin
    int nacc;
    int nstrb;
    int s0;
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 48'h0;
    bus.mode     = 8'h00;
    set_dsel(12'h000);

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_out", 64'(bus.out_data), 64'(pk(12'h800, 12'h800, 12'h800, 12'h800)));
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_strobes", 64'(strobes), 64'd0);

    // pass / mirror / mute / hold against midscale history
    run_frame("mix", pk(12'h123, 12'h123, 12'h123, 12'h123), 8'hE4,
              pk(12'h123, 12'hEDC, 12'h800, 12'h800));

    // All mirror, including both rails
    run_frame("mir", pk(12'h000, 12'hFFF, 12'd200, 12'd3000), 8'h55,
              pk(12'hFFF, 12'h000, 12'd3895, 12'd1095));

    // All hold keeps the previous frame
    run_frame("hold", pk(12'h001, 12'h002, 12'h003, 12'h004), 8'hFF,
              pk(12'hFFF, 12'h000, 12'd3895, 12'd1095));

    // in_valid held with changing data: accepts at cycles 0, 6, 12
    wait_ready("stream");
    s0    = strobes;
    nacc  = 0;
    nstrb = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid) begin
        nstrb++;
        chk("stream_data", 64'(bus.out_data), 64'(pkc(c - 6)));
      end
      if (c < 18 && bus.in_ready) nacc++;
      bus.in_valid = (c < 18);
      bus.in_data  = pkc(c);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("stream_accepts", 64'(nacc), 64'd3);
    chk("stream_strobes", 64'(nstrb), 64'd3);
    chk("stream_strobe_cnt", 64'(strobes - s0), 64'd3);

    // Reset while scanning
    wait_ready("rstscan");
    bus.in_data  = pk(12'h111, 12'h222, 12'h333, 12'h444);
    bus.mode     = 8'h00;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    s0  = strobes;
    repeat (8) @(negedge clk);
    chk("rstscan_strobes", 64'(strobes - s0), 64'd0);
    chk("rstscan_out", 64'(bus.out_data), 64'(pk(12'h800, 12'h800, 12'h800, 12'h800)));
    chk("rstscan_busy", 64'(bus.busy), 64'd0);
    run_frame("post_rst", pk(12'hABC, 12'h001, 12'h002, 12'h003), 8'h00,
              pk(12'hABC, 12'h001, 12'h002, 12'h003));

`ifdef SPKR_INV_DELAY_EN
    // ch0 delayed by 2 frames; midscale until the line fills
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_dsel(12'h002);
    run_frame("dly0", pk(12'd10, 12'h111, 12'h222, 12'h333), 8'h00,
              pk(12'h800, 12'h111, 12'h222, 12'h333));
    set_dsel(12'h002);
    run_frame("dly1", pk(12'd20, 12'h111, 12'h222, 12'h333), 8'h00,
              pk(12'h800, 12'h111, 12'h222, 12'h333));
    set_dsel(12'h002);
    run_frame("dly2", pk(12'd30, 12'h111, 12'h222, 12'h333), 8'h00,
              pk(12'd10, 12'h111, 12'h222, 12'h333));
    set_dsel(12'h002);
    run_frame("dly3", pk(12'd40, 12'h111, 12'h222, 12'h333), 8'h00,
              pk(12'd20, 12'h111, 12'h222, 12'h333));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
